// File: rtl/slot_allocator_pkg.sv
// Shared types and constants for the parking-lot slot allocator.
// Spot count is fixed at 8 to match the downstream ones counter.
package slot_allocator_pkg;

  localparam int unsigned SLOT_CNT = 8;
  localparam int unsigned SLOT_W   = 3;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2
  } state_e;

  typedef struct packed {
    logic enter_ack;
    logic enter_reject;
    logic exit_ack;
    logic exit_err;
    logic timeout;
  } pulse_t;

endpackage

// File: rtl/slot_allocator_lowest_free_slot.sv
// Combinational priority encoder: index of the lowest set bit of free_mask.
module slot_allocator_lowest_free_slot
  import slot_allocator_pkg::*;
(
  input  logic [SLOT_CNT-1:0] free_mask,
  output logic                found,
  output logic [SLOT_W-1:0]   index
);

  // Scan from the top so the lowest free index is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = SLOT_CNT - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        found = 1'b1;
        index = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/slot_allocator.sv
// Parking-lot spot allocator: occupancy tracking plus entry/exit gate sequencing.
// Optional PARKING_RESERVED_SLOT_EN reserves spot 7 for VIP cars (adds enter_vip).
module slot_allocator
  import slot_allocator_pkg::*;
#(
  parameter int unsigned GATE_TIMEOUT = 16,
  parameter int unsigned N_SLOTS      = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enter_req,
`ifdef PARKING_RESERVED_SLOT_EN
  input  logic               enter_vip,
`endif
  input  logic               exit_req,
  input  logic [SLOT_W-1:0]  exit_slot,
  input  logic               car_passed,
  output logic [N_SLOTS-1:0] new_capacity,
  output logic [SLOT_W-1:0]  assigned_slot,
  output logic               entry_gate_open,
  output logic               exit_gate_open,
  output logic               enter_ack,
  output logic               enter_reject,
  output logic               exit_ack,
  output logic               exit_err,
  output logic               timeout,
  output logic               full
);

  localparam int unsigned TMR_W = $clog2(GATE_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [N_SLOTS-1:0] occ_d;
  logic [SLOT_W-1:0]  slot_d;
  logic [SLOT_W-1:0]  exit_slot_q, exit_slot_d;
  pulse_t             pulse_d;
  logic [N_SLOTS-1:0] free_mask;
  logic               free_found;
  logic [SLOT_W-1:0]  free_idx;

  // Non-VIP cars never see spot 7 as free in reserved mode.
  always_comb begin
    free_mask = ~new_capacity;
`ifdef PARKING_RESERVED_SLOT_EN
    if (!enter_vip) free_mask[N_SLOTS-1] = 1'b0;
`endif
  end

  slot_allocator_lowest_free_slot u_lowest_free_slot (
    .free_mask (free_mask),
    .found     (free_found),
    .index     (free_idx)
  );

  assign full = (new_capacity == '1);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    occ_d       = new_capacity;
    slot_d      = assigned_slot;
    exit_slot_d = exit_slot_q;
    pulse_d     = '0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        // Exit wins a tie so the freed spot is visible to the next entry.
        if (exit_req) begin
          if (new_capacity[exit_slot]) begin
            state_d     = EXIT_OPEN;
            exit_slot_d = exit_slot;
          end else begin
            pulse_d.exit_err = 1'b1;
          end
        end else if (enter_req) begin
          if (free_found) begin
            state_d = ENTRY_OPEN;
            slot_d  = free_idx;
          end else begin
            pulse_d.enter_reject = 1'b1;
          end
        end
      end
      ENTRY_OPEN: begin
        if (car_passed) begin
          occ_d[assigned_slot] = 1'b1;
          pulse_d.enter_ack    = 1'b1;
          state_d              = IDLE;
          timer_d              = '0;
        end else if (timer_q == TMR_W'(GATE_TIMEOUT - 1)) begin
          pulse_d.timeout = 1'b1;
          state_d         = IDLE;
          timer_d         = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      EXIT_OPEN: begin
        if (car_passed) begin
          occ_d[exit_slot_q] = 1'b0;
          pulse_d.exit_ack   = 1'b1;
          state_d            = IDLE;
          timer_d            = '0;
        end else if (timer_q == TMR_W'(GATE_TIMEOUT - 1)) begin
          pulse_d.timeout = 1'b1;
          state_d         = IDLE;
          timer_d         = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      timer_q         <= '0;
      exit_slot_q     <= '0;
      new_capacity    <= '0;
      assigned_slot   <= '0;
      entry_gate_open <= 1'b0;
      exit_gate_open  <= 1'b0;
      enter_ack       <= 1'b0;
      enter_reject    <= 1'b0;
      exit_ack        <= 1'b0;
      exit_err        <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      exit_slot_q     <= exit_slot_d;
      new_capacity    <= occ_d;
      assigned_slot   <= slot_d;
      entry_gate_open <= (state_d == ENTRY_OPEN);
      exit_gate_open  <= (state_d == EXIT_OPEN);
      enter_ack       <= pulse_d.enter_ack;
      enter_reject    <= pulse_d.enter_reject;
      exit_ack        <= pulse_d.exit_ack;
      exit_err        <= pulse_d.exit_err;
      timeout         <= pulse_d.timeout;
    end
  end

endmodule
